// File: rtl/cmp_pkg.sv
// Comparison encoding shared with the upstream running comparator, plus the
// sequencing states of the conditional block subtractor.
package cmp_pkg;

    localparam logic [1:0] CMP_NULL = 2'b00;
    localparam logic [1:0] CMP_LT   = 2'b01;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_EQ   = 2'b11;

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_DECIDE = 2'b01,
        ST_DRAIN  = 2'b10
    } cbs_state_t;

    // A >= B is the only ordering that selects the subtraction path.
    function automatic logic cmp_a_ge_b(input logic [1:0] cmp);
        return (cmp == CMP_GT) || (cmp == CMP_EQ);
    endfunction

    function automatic logic cmp_is_null(input logic [1:0] cmp);
        return cmp == CMP_NULL;
    endfunction

endpackage

// File: rtl/conditional_block_subtractor_if.sv
// Operand/result stream bundle between the comparator stage, the conditional
// subtractor and its downstream consumer.
interface conditional_block_subtractor_if #(
    parameter int REGISTER_SIZE = 32
);
    logic                     valid_in;
    logic [REGISTER_SIZE-1:0] block_a_in;
    logic [REGISTER_SIZE-1:0] block_b_in;
    logic                     ready_out;
    logic [1:0]               comparison_in;
    logic                     valid_out;
    logic [REGISTER_SIZE-1:0] block_out;
    logic                     last_out;
    logic                     ready_in;
    logic                     error_out;

    modport master (
        output valid_in,
        output block_a_in,
        output block_b_in,
        output comparison_in,
        output ready_in,
        input  ready_out,
        input  valid_out,
        input  block_out,
        input  last_out,
        input  error_out
    );

    modport slave (
        input  valid_in,
        input  block_a_in,
        input  block_b_in,
        input  comparison_in,
        input  ready_in,
        output ready_out,
        output valid_out,
        output block_out,
        output last_out,
        output error_out
    );

endinterface

// File: rtl/block_subtractor.sv
// One limb of the borrow chain: diff = a - b - borrow_in mod 2^REGISTER_SIZE.
module block_subtractor #(
    parameter int REGISTER_SIZE = 32
) (
    input  logic [REGISTER_SIZE-1:0] a,
    input  logic [REGISTER_SIZE-1:0] b,
    input  logic                     borrow_in,
    output logic [REGISTER_SIZE-1:0] diff,
    output logic                     borrow_out
);

    logic [REGISTER_SIZE:0] wide;

    // The extra top bit goes negative exactly when a < b + borrow_in.
    assign wide = {1'b0, a} - {1'b0, b} - {{REGISTER_SIZE{1'b0}}, borrow_in};
    assign diff       = wide[REGISTER_SIZE-1:0];
    assign borrow_out = wide[REGISTER_SIZE];

endmodule

// File: rtl/conditional_block_subtractor.sv
// Buffers an A/B operand pair, then streams out A - B when A >= B, else A,
// least-significant block first with a block-serial borrow chain.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_FILL   | accepting {A,B} blocks into the buffer, ready_out high
//   ST_DECIDE | one cycle: sample comparator, load block 0 into output reg
//   ST_DRAIN  | stream remaining blocks under ready_in backpressure
module conditional_block_subtractor
    import cmp_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    conditional_block_subtractor_if.slave  bus
);

    localparam int                WORD_W   = 2 * REGISTER_SIZE;
    localparam int                IDX_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    cbs_state_t                state;
    cbs_state_t                state_nxt;
    logic [IDX_W-1:0]          idx;
    logic                      borrow;
    logic                      subtract;
    logic                      valid_q;
    logic                      last_q;
    logic                      error_q;
    logic [REGISTER_SIZE-1:0]  block_q;

    logic [WORD_W-1:0]         buffer [NUM_BLOCKS];
    logic [WORD_W-1:0]         rd_word;
    logic [REGISTER_SIZE-1:0]  rd_a;
    logic [REGISTER_SIZE-1:0]  rd_b;
    logic [REGISTER_SIZE-1:0]  diff;
    logic                      borrow_out;

    logic                      accept;
    logic                      load;
    logic                      last_hs;
    logic                      dec_subtract;
    logic                      sub_now;
    logic                      borrow_now;
    logic                      idx_at_last;

    assign bus.ready_out = rst_in && (state == ST_FILL);
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.error_out = error_q;
    assign bus.block_out = block_q;

    assign accept       = bus.valid_in && bus.ready_out;
    assign idx_at_last  = (idx == LAST_IDX);
    assign dec_subtract = cmp_a_ge_b(bus.comparison_in);

    // Block 0 is loaded on the DECIDE edge so the drain takes NUM_BLOCKS cycles;
    // the decision and a cleared borrow are applied directly in that cycle.
    assign sub_now    = (state == ST_DECIDE) ? dec_subtract : subtract;
    assign borrow_now = (state == ST_DECIDE) ? 1'b0 : borrow;

    assign last_hs = (state == ST_DRAIN) && valid_q && last_q && bus.ready_in;
    assign load    = (state == ST_DECIDE) ||
                     ((state == ST_DRAIN) && (!valid_q || bus.ready_in) && !(valid_q && last_q));

    assign rd_word      = buffer[idx];
    assign {rd_a, rd_b} = rd_word;

    block_subtractor #(
        .REGISTER_SIZE (REGISTER_SIZE)
    ) u_block_subtractor (
        .a          (rd_a),
        .b          (rd_b),
        .borrow_in  (borrow_now),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // Single write port, no reset: keeps the buffer mappable to LUTRAM/BRAM.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            buffer[idx] <= {bus.block_a_in, bus.block_b_in};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FILL:   if (accept && idx_at_last) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = ST_DRAIN;
            ST_DRAIN:  if (last_hs) state_nxt = ST_FILL;
            default:   state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx      <= '0;
            borrow   <= 1'b0;
            subtract <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
            block_q  <= '0;
        end else begin
            error_q <= 1'b0;

            if (accept) begin
                idx <= idx_at_last ? '0 : idx + 1'b1;
            end

            if (state == ST_DECIDE) begin
                subtract <= dec_subtract;
                error_q  <= cmp_is_null(bus.comparison_in);
            end

            if (load) begin
                block_q <= sub_now ? diff : rd_a;
                borrow  <= sub_now ? borrow_out : 1'b0;
                valid_q <= 1'b1;
                last_q  <= idx_at_last;
                idx     <= idx_at_last ? '0 : idx + 1'b1;
            end else if (last_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

endmodule
